// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared encodings for the memory-access stage: funct3 load/store
//           codes, ResultSrc encodings, access-size helper and the M-stage
//           FSM state type.
// Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // funct3 load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3 store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Access sizes
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // funct3[1:0] alone determines the size for both loads and stores; every
    // encoding that is not byte or half (including the reserved load codes)
    // is handled as a word access.
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_size = SZ_B;
            2'b01:   access_size = SZ_H;
            default: access_size = SZ_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational load/store alignment unit.
//           Ports: i_funct3     access size / sign select
//                  i_addr_lo    byte offset within the word
//                  i_store_data store source register value
//                  i_rdata      raw memory read word
//                  o_wdata      lane-replicated store data
//                  o_wstrb      byte enables for a store
//                  o_load_data  extracted and extended load value
//                  o_misalign   access crosses its natural alignment
// Rev     : 1.0  initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    logic [1:0]  w_size;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_size    = access_size(i_funct3);
    assign w_signed  = ~i_funct3[2];
    // Bring the addressed byte down to lane 0
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wdata     = i_store_data;
        o_wstrb     = 4'b1111;
        o_load_data = i_rdata;
        o_misalign  = 1'b0;
        case (w_size)
            SZ_B: begin
                o_wdata     = {4{i_store_data[7:0]}};
                o_wstrb     = 4'b0001 << i_addr_lo;
                o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_wdata     = {2{i_store_data[15:0]}};
                o_wstrb     = 4'b0011 << i_addr_lo;
                o_load_data = {{16{w_signed & w_half[15]}}, w_half};
                o_misalign  = i_addr_lo[0];
            end
            default: begin
                o_misalign  = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
// Module  : memory_cycle
// Purpose : Memory-access pipeline stage. Issues single-outstanding data
//           memory requests, stalls upstream while waiting for ack, and
//           registers results into the MEM/WB register.
//           Ports: clk/rst (async active-low), M-stage inputs from execute,
//                  dmem_* request/ack memory port, StallM to the hazard
//                  unit, MisalignM pulse, *W MEM/WB register outputs.
// Rev     : 1.0  initial release
// ============================================================================
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [31:0]     InstrM,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            StallM,
    output logic            MisalignM,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW
);

    mem_state_t  r_state;
    mem_state_t  w_state_next;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_memop;
    logic        w_misalign;
    logic        w_misalign_op;
    logic        w_access;
    logic        w_req;
    logic        w_stall;
    logic        w_done;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_load_data;
    logic        w_unused_instr;

    // Only funct3 of the instruction word matters in this stage
    assign w_unused_instr = ^{InstrM[31:15], InstrM[11:0]};

    assign w_is_load     = (ResultSrcM == RES_MEM);
    assign w_is_store    = MemWriteM;
    assign w_memop       = w_is_load | w_is_store;
    assign w_misalign_op = w_memop & w_misalign;
    assign w_access      = w_memop & ~w_misalign;

    lsu_align u_lsu_align (
        .i_funct3     (InstrM[14:12]),
        .i_addr_lo    (ALUResultM[1:0]),
        .i_store_data (WriteDataM),
        .i_rdata      (dmem_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    // Next-state and request generation. In WAIT the M inputs are frozen by
    // the stall, so the request is simply held until ack.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            IDLE: begin
                w_req = w_access;
                if (w_access && !dmem_ack) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (dmem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Combinational outputs are gated by reset so an aborted request drops
    // the moment reset is asserted, not at the next edge.
    assign w_done     = w_req & dmem_ack;
    assign w_stall    = w_req & ~dmem_ack;
    assign dmem_req   = w_req & rst;
    assign StallM     = w_stall & rst;
    assign MisalignM  = w_misalign_op & rst;
    assign dmem_we    = dmem_req & w_is_store;
    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_wstrb = (dmem_req && w_is_store) ? w_wstrb : 4'b0000;

    // MEM/WB register: bubble while stalled, M fields otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
        end else if (w_stall) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= (w_done && w_is_load) ? w_load_data : '0;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM & ~w_misalign_op;
            ResultSrcW <= ResultSrcM;
        end
    end

endmodule
`default_nettype wire
